// File: rtl/get_code.sv
// rtl/get_code.sv - keypad code-entry controller: debounced multi-digit capture with timeout abort
// Collects DIGITS key presses into a packed code word and holds it until acknowledged.
module get_code #(
  parameter int DIGITS   = 2,
  parameter int KEY_W    = 4,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           apt,
  input  logic [KEY_W-1:0]               key_code,
  input  logic                           clear,
  input  logic                           ack,
  output logic [DIGITS*KEY_W-1:0]        code_out,
  output logic                           code_valid,
  output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
  output logic                           timeout,
  output logic [1:0]                     state_now
);

  localparam int CW    = DIGITS * KEY_W;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DEB  = 2'b01,
    S_REL  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t             r_state;
  logic [DEB_W-1:0]   r_deb;
  logic [TMR_W-1:0]   r_tmr;
  logic [CW-1:0]      r_code;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_timeout;

  state_t             w_state_nxt;
  logic [DEB_W-1:0]   w_deb_nxt;
  logic [TMR_W-1:0]   w_tmr_nxt;
  logic [CW-1:0]      w_code_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_valid_nxt;
  logic               w_timeout_nxt;
  logic               w_qual;
  logic               w_to_hit;
  logic [CW-1:0]      w_key_ext;

  // A partial entry is one with at least one digit that has not yet completed.
  assign w_qual    = (r_cnt != '0) && (r_state != S_DONE);
  assign w_to_hit  = w_qual && (r_tmr == TMR_W'(TIMEOUT - 1));
  assign w_key_ext = CW'(key_code);

  always_comb begin
    w_state_nxt   = r_state;
    w_deb_nxt     = r_deb;
    w_tmr_nxt     = w_qual ? (r_tmr + TMR_W'(1)) : '0;
    w_code_nxt    = r_code;
    w_cnt_nxt     = r_cnt;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;

    if (clear || w_to_hit) begin
      // A key still held across the abort must be released before it can count.
      w_state_nxt   = apt ? S_REL : S_IDLE;
      w_deb_nxt     = '0;
      w_tmr_nxt     = '0;
      w_code_nxt    = '0;
      w_cnt_nxt     = '0;
      w_valid_nxt   = 1'b0;
      w_timeout_nxt = !clear;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (apt) begin
            w_state_nxt = S_DEB;
            w_deb_nxt   = '0;
          end
        end
        S_DEB: begin
          if (!apt) begin
            w_state_nxt = S_IDLE;
            w_deb_nxt   = '0;
          end else if (r_deb == DEB_W'(DEBOUNCE - 1)) begin
            w_code_nxt  = (r_code << KEY_W) | w_key_ext;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_tmr_nxt   = '0;
            w_deb_nxt   = '0;
            w_state_nxt = S_REL;
          end else begin
            w_deb_nxt = r_deb + DEB_W'(1);
          end
        end
        S_REL: begin
          if (!apt) begin
            if (r_cnt == CNT_W'(DIGITS)) begin
              w_state_nxt = S_DONE;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (ack) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_code_nxt  = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_deb     <= '0;
      r_tmr     <= '0;
      r_code    <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb     <= w_deb_nxt;
      r_tmr     <= w_tmr_nxt;
      r_code    <= w_code_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign code_out   = r_code;
  assign code_valid = r_valid;
  assign digit_cnt  = r_cnt;
  assign timeout    = r_timeout;
  assign state_now  = r_state;

endmodule

// File: tb/tb_get_code.sv
// tb/tb_get_code.sv - self-checking bench for get_code with a completed-code scoreboard
module tb_get_code;

  localparam int DIGITS   = 2;
  localparam int KEY_W    = 4;
  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 20;

  logic        clk;
  logic        rst;
  logic        apt;
  logic [3:0]  key_code;
  logic        clear;
  logic        ack;
  logic [7:0]  code_out;
  logic        code_valid;
  logic [1:0]  digit_cnt;
  logic        timeout;
  logic [1:0]  state_now;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  get_code #(
    .DIGITS(DIGITS), .KEY_W(KEY_W), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .apt(apt), .key_code(key_code), .clear(clear), .ack(ack),
    .code_out(code_out), .code_valid(code_valid), .digit_cnt(digit_cnt),
    .timeout(timeout), .state_now(state_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press, hold exactly long enough to capture, then release one edge.
  task automatic enter_key(input logic [3:0] k);
    apt = 1'b1; key_code = k;
    step(DEBOUNCE + 1);
    apt = 1'b0;
    step(1);
  endtask

  task automatic collect(input string name);
    int n;
    logic [7:0] exp;
    n = 0;
    while (!code_valid && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (!code_valid) begin
      errors++;
      $display("FAIL %s_wait: code_valid=%0b after %0d cycles, required 1", name, code_valid, n);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: code 0x%h produced, required none pending", name, code_out);
    end else begin
      exp = exp_q.pop_front();
      if (code_out !== exp) begin
        errors++;
        $display("FAIL %s_code: code_out=0x%h required 0x%h", name, code_out, exp);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; apt = 1'b0; key_code = '0; clear = 1'b0; ack = 1'b0;
    step(2);
    checks++;
    if ({state_now, digit_cnt, code_out, code_valid, timeout} !== 14'd0) begin
      errors++;
      $display("FAIL reset_init: st=%0d cnt=%0d code=0x%h v=%0b to=%0b required all 0",
               state_now, digit_cnt, code_out, code_valid, timeout);
    end
    rst = 1'b1;
    step(1);
    apt = 1'b1; key_code = 4'h3;
    step(DEBOUNCE + 1);
    checks++;
    if (digit_cnt !== 2'd1) begin
      errors++;
      $display("FAIL reset_precap: digit_cnt=%0d required 1", digit_cnt);
    end
    apt = 1'b0;
    step(1);
    apt = 1'b1;
    step(2);
    checks++;
    if (state_now !== 2'b01 || digit_cnt !== 2'd1) begin
      errors++;
      $display("FAIL reset_middeb: st=%0d cnt=%0d required 1 1", state_now, digit_cnt);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if ({state_now, digit_cnt, code_out, code_valid} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid: st=%0d cnt=%0d code=0x%h v=%0b required all 0",
               state_now, digit_cnt, code_out, code_valid);
    end
    rst = 1'b1; apt = 1'b0;
    step(1);
  endtask

  task automatic test_nominal;
    apt = 1'b1; key_code = 4'h7;
    step(6);
    checks++;
    if (digit_cnt !== 2'd1 || code_out !== 8'h07 || state_now !== 2'b10) begin
      errors++;
      $display("FAIL nom_first: cnt=%0d code=0x%h st=%0d required 1 0x07 2", digit_cnt, code_out, state_now);
    end
    apt = 1'b0;
    step(1);
    exp_q.push_back(8'h7A);
    apt = 1'b1; key_code = 4'hA;
    step(6);
    checks++;
    if (code_valid !== 1'b0) begin
      errors++;
      $display("FAIL nom_early_valid: code_valid=%0b required 0", code_valid);
    end
    apt = 1'b0;
    step(1);
    checks++;
    if (code_valid !== 1'b1 || state_now !== 2'b11) begin
      errors++;
      $display("FAIL nom_release: v=%0b st=%0d required 1 3", code_valid, state_now);
    end
    collect("nom");
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    checks++;
    if (code_valid !== 1'b0 || code_out !== 8'h00 || state_now !== 2'b00 || digit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL nom_ack: v=%0b code=0x%h st=%0d cnt=%0d required 0 0x00 0 0",
               code_valid, code_out, state_now, digit_cnt);
    end
  endtask

  task automatic test_bounce;
    apt = 1'b1; key_code = 4'h3;
    step(3);
    apt = 1'b0;
    step(1);
    checks++;
    if (digit_cnt !== 2'd0 || state_now !== 2'b00) begin
      errors++;
      $display("FAIL bounce_short: cnt=%0d st=%0d required 0 0", digit_cnt, state_now);
    end
    apt = 1'b1;
    step(10);
    checks++;
    if (digit_cnt !== 2'd1 || code_out !== 8'h03) begin
      errors++;
      $display("FAIL bounce_long: cnt=%0d code=0x%h required 1 0x03", digit_cnt, code_out);
    end
    apt = 1'b0;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checks++;
    if (digit_cnt !== 2'd0 || code_out !== 8'h00 || timeout !== 1'b0 || state_now !== 2'b00) begin
      errors++;
      $display("FAIL bounce_clear: cnt=%0d code=0x%h to=%0b st=%0d required 0 0x00 0 0",
               digit_cnt, code_out, timeout, state_now);
    end
  endtask

  task automatic test_timeout;
    int pulses;
    apt = 1'b1; key_code = 4'h5;
    step(DEBOUNCE + 1);
    checks++;
    if (digit_cnt !== 2'd1 || code_out !== 8'h05) begin
      errors++;
      $display("FAIL to_capture: cnt=%0d code=0x%h required 1 0x05", digit_cnt, code_out);
    end
    step(TIMEOUT - 1);
    checks++;
    if (timeout !== 1'b0 || digit_cnt !== 2'd1) begin
      errors++;
      $display("FAIL to_early: to=%0b cnt=%0d required 0 1", timeout, digit_cnt);
    end
    step(1);
    checks++;
    if (timeout !== 1'b1 || digit_cnt !== 2'd0 || state_now !== 2'b10 || code_out !== 8'h00) begin
      errors++;
      $display("FAIL to_fire: to=%0b cnt=%0d st=%0d code=0x%h required 1 0 2 0x00",
               timeout, digit_cnt, state_now, code_out);
    end
    step(1);
    checks++;
    if (timeout !== 1'b0 || state_now !== 2'b10) begin
      errors++;
      $display("FAIL to_pulse: to=%0b st=%0d required 0 2", timeout, state_now);
    end
    apt = 1'b0;
    pulses = 0;
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      step(1);
      if (timeout) pulses++;
    end
    checks++;
    if (state_now !== 2'b00 || digit_cnt !== 2'd0 || pulses != 0) begin
      errors++;
      $display("FAIL to_release: st=%0d cnt=%0d pulses=%0d required 0 0 0", state_now, digit_cnt, pulses);
    end
  endtask

  task automatic test_clear_capture;
    apt = 1'b1; key_code = 4'h9;
    step(DEBOUNCE);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checks++;
    if (digit_cnt !== 2'd0 || code_out !== 8'h00 || timeout !== 1'b0 || state_now !== 2'b10) begin
      errors++;
      $display("FAIL clr_cap: cnt=%0d code=0x%h to=%0b st=%0d required 0 0x00 0 2",
               digit_cnt, code_out, timeout, state_now);
    end
    apt = 1'b0;
    step(1);
    checks++;
    if (state_now !== 2'b00 || digit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL clr_idle: st=%0d cnt=%0d required 0 0", state_now, digit_cnt);
    end
  endtask

  task automatic test_done_immunity;
    int bad;
    exp_q.push_back(8'h12);
    enter_key(4'h1);
    enter_key(4'h2);
    collect("done");
    apt = 1'b1; key_code = 4'hF;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (code_out !== 8'h12 || timeout !== 1'b0 || state_now !== 2'b11 || code_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_hold: %0d disturbed cycles, code=0x%h required 0 and 0x12", bad, code_out);
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    checks++;
    if (state_now !== 2'b00 || code_valid !== 1'b0 || code_out !== 8'h00) begin
      errors++;
      $display("FAIL done_ack: st=%0d v=%0b code=0x%h required 0 0 0x00", state_now, code_valid, code_out);
    end
    step(1);
    checks++;
    if (state_now !== 2'b01) begin
      errors++;
      $display("FAIL done_deb: st=%0d required 1", state_now);
    end
    step(DEBOUNCE - 1);
    checks++;
    if (digit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL done_nocap: cnt=%0d required 0", digit_cnt);
    end
    step(1);
    checks++;
    if (digit_cnt !== 2'd1 || code_out !== 8'h0F) begin
      errors++;
      $display("FAIL done_cap: cnt=%0d code=0x%h required 1 0x0F", digit_cnt, code_out);
    end
    apt = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
  endtask

  task automatic test_back_to_back;
    logic [3:0] keys [4];
    keys[0] = 4'h4; keys[1] = 4'h5; keys[2] = 4'hB; keys[3] = 4'hC;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back({keys[2*c], keys[2*c+1]});
      enter_key(keys[2*c]);
      enter_key(keys[2*c+1]);
      collect("b2b");
      ack = 1'b1;
      step(1);
      ack = 1'b0;
    end
    // ack while idle must not disturb a fresh partial entry
    enter_key(4'h8);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    checks++;
    if (digit_cnt !== 2'd1 || code_out !== 8'h08 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_stray_ack: cnt=%0d code=0x%h pending=%0d required 1 0x08 0",
               digit_cnt, code_out, exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nominal();
    test_bounce();
    test_timeout();
    test_clear_capture();
    test_done_immunity();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
